// File: rtl/trigger_arbiter.sv
// Four-channel round-robin trigger arbiter: edge-detects per-channel requests, issues one
// trigger per grant, then waits a fixed number of frame boundaries plus an optional holdoff.
module trigger_arbiter #(
  parameter int unsigned HOLDOFF_W          = 16,
  parameter int unsigned FRAMES_PER_TRIGGER = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [3:0]           trig_req_i,
  input  logic [3:0]           enable_i,
  input  logic [HOLDOFF_W-1:0] holdoff_i,
  input  logic                 frame_boundary_i,
  input  logic                 overflow_clr_i,
  output logic                 trigger_pulse_o,
  output logic [1:0]           trigger_channel_o,
  output logic [3:0]           ack_o,
  output logic                 busy_o,
  output logic [3:0]           overflow_o,
  output logic [15:0]          trigger_count_o
);

  localparam int unsigned FrameW =
      (FRAMES_PER_TRIGGER > 1) ? $clog2(FRAMES_PER_TRIGGER) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWaitFrame, StHoldoff} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             req_q;
  logic [3:0]             pending_q, pending_d;
  logic [3:0]             overflow_q, overflow_d;
  logic [1:0]             chan_q, chan_d;
  logic [1:0]             last_q, last_d;
  logic [15:0]            trigger_count_q, trigger_count_d;
  logic [FrameW-1:0]      frame_q, frame_d;
  logic [HOLDOFF_W-1:0]   hold_q, hold_d;
  logic                   pulse_q, pulse_d;
  logic [3:0]             ack_q, ack_d;

  logic [3:0] edge_det, eligible, issue_clr;
  logic [1:0] winner, idx;
  logic       found;

  assign edge_det  = trig_req_i & ~req_q & enable_i;
  assign eligible  = pending_q & enable_i;
  assign issue_clr = (state_q == StIssue) ? (4'b0001 << chan_q) : 4'b0000;

  // A new edge wins over the ISSUE clear, so a request landing on its own grant cycle survives.
  assign pending_d  = ((pending_q & ~issue_clr) | edge_det) & enable_i;
  assign overflow_d = (overflow_q & ~{4{overflow_clr_i}}) | (edge_det & pending_q & ~issue_clr);

  always_comb begin
    winner = last_q;
    idx    = 2'd0;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    chan_d          = chan_q;
    last_d          = last_q;
    trigger_count_d = trigger_count_q;
    frame_d         = frame_q;
    hold_d          = hold_q;
    pulse_d         = 1'b0;
    ack_d           = 4'b0000;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          chan_d  = winner;
          state_d = StIssue;
        end
      end
      StIssue: begin
        pulse_d         = 1'b1;
        ack_d           = 4'b0001 << chan_q;
        last_d          = chan_q;
        trigger_count_d = trigger_count_q + 16'd1;
        frame_d         = '0;
        state_d         = StWaitFrame;
      end
      StWaitFrame: begin
        if (frame_boundary_i) begin
          if (frame_q == FrameW'(FRAMES_PER_TRIGGER - 1)) begin
            if (holdoff_i != '0) begin
              hold_d  = holdoff_i;
              state_d = StHoldoff;
            end else begin
              state_d = StIdle;
            end
          end else begin
            frame_d = frame_q + FrameW'(1);
          end
        end
      end
      StHoldoff: begin
        hold_d = hold_q - HOLDOFF_W'(1);
        if (hold_q <= HOLDOFF_W'(1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= StIdle;
      req_q           <= 4'b1111;
      pending_q       <= 4'b0000;
      overflow_q      <= 4'b0000;
      chan_q          <= 2'd0;
      last_q          <= 2'd3;
      trigger_count_q <= 16'd0;
      frame_q         <= '0;
      hold_q          <= '0;
      pulse_q         <= 1'b0;
      ack_q           <= 4'b0000;
    end else begin
      state_q         <= state_d;
      req_q           <= trig_req_i;
      pending_q       <= pending_d;
      overflow_q      <= overflow_d;
      chan_q          <= chan_d;
      last_q          <= last_d;
      trigger_count_q <= trigger_count_d;
      frame_q         <= frame_d;
      hold_q          <= hold_d;
      pulse_q         <= pulse_d;
      ack_q           <= ack_d;
    end
  end

  assign trigger_pulse_o   = pulse_q;
  assign ack_o             = ack_q;
  assign trigger_channel_o = chan_q;
  assign busy_o            = (state_q != StIdle);
  assign overflow_o        = overflow_q;
  assign trigger_count_o   = trigger_count_q;

endmodule

// File: tb/tb_trigger_arbiter.sv
// Bench for trigger_arbiter: a timeline-level reference model checked every cycle, plus
// directed scenarios with literal expectations (latency, ordering, merge, holdoff, masking).
module tb_trigger_arbiter;
  localparam int unsigned HW  = 16;
  localparam int unsigned FPT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    trig_req, enable;
  logic [HW-1:0] holdoff;
  logic          fb, ovf_clr;
  logic          pulse, busy;
  logic [1:0]    chan;
  logic [3:0]    ack, ovf;
  logic [15:0]   count;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;
  int grants[$];
  int fb_per = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  trigger_arbiter #(
    .HOLDOFF_W          (HW),
    .FRAMES_PER_TRIGGER (FPT)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .trig_req_i        (trig_req),
    .enable_i          (enable),
    .holdoff_i         (holdoff),
    .frame_boundary_i  (fb),
    .overflow_clr_i    (ovf_clr),
    .trigger_pulse_o   (pulse),
    .trigger_channel_o (chan),
    .ack_o             (ack),
    .busy_o            (busy),
    .overflow_o        (ovf),
    .trigger_count_o   (count)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference model: pending set, overflow set, and a grant timeline
  // (issue now -> frames still owed -> holdoff clocks still owed -> free).
  logic [3:0]  m_pend, m_ovf, m_prev, m_ack;
  logic        m_pulse, m_issue_now;
  logic [15:0] m_count;
  int          m_last, m_chan, m_frames_left, m_hold_left;
  logic        m_busy;

  assign m_busy = m_issue_now || (m_frames_left > 0) || (m_hold_left > 0);

  always @(posedge clk or negedge rst_n) begin : model
    logic [3:0] e, clr, pn, on;
    int w, c;
    bit hit;
    if (!rst_n) begin
      m_pend <= '0; m_ovf <= '0; m_prev <= 4'hF; m_ack <= '0; m_pulse <= 1'b0;
      m_issue_now <= 1'b0; m_count <= '0; m_last <= 3; m_chan <= 0;
      m_frames_left <= 0; m_hold_left <= 0;
    end else begin
      e   = trig_req & ~m_prev & enable;
      clr = m_issue_now ? (4'b0001 << m_chan) : 4'b0000;
      for (int i = 0; i < 4; i++) begin
        pn[i] = enable[i] && (e[i] || (m_pend[i] && !clr[i]));
        on[i] = (e[i] && m_pend[i] && !clr[i]) || (m_ovf[i] && !ovf_clr);
      end
      m_pend  <= pn;
      m_ovf   <= on;
      m_prev  <= trig_req;
      m_pulse <= m_issue_now;
      m_ack   <= clr;
      if (m_issue_now) begin
        m_issue_now   <= 1'b0;
        m_last        <= m_chan;
        m_count       <= m_count + 16'd1;
        m_frames_left <= FPT;
      end else if (m_frames_left > 0) begin
        if (fb) begin
          m_frames_left <= m_frames_left - 1;
          if (m_frames_left == 1) m_hold_left <= int'(holdoff);
        end
      end else if (m_hold_left > 0) begin
        m_hold_left <= m_hold_left - 1;
      end else begin
        hit = 1'b0;
        w   = 0;
        for (int k = 1; k <= 4; k++) begin
          c = (m_last + k) % 4;
          if (!hit && m_pend[c] && enable[c]) begin
            hit = 1'b1;
            w   = c;
          end
        end
        if (hit) begin
          m_chan      <= w;
          m_issue_now <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("pulse", pulse, m_pulse);
      check("ack", ack, m_ack);
      check("chan", chan, m_chan[1:0]);
      check("busy", busy, m_busy);
      check("overflow", ovf, m_ovf);
      check("count", count, m_count);
      for (int i = 0; i < 4; i++) if (ack[i]) grants.push_back(i);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
      cyc++;
      if (fb_per != 0) fb = ((cyc % fb_per) == 0);
    end
  endtask

  task automatic pulse_fb();
    fb = 1'b1;
    tick();
    fb = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pulse"}, pulse, 1'b0);
    check({tag, "_ack"}, ack, 4'h0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_ovf"}, ovf, 4'h0);
    check({tag, "_count"}, count, 16'h0);
    check({tag, "_chan"}, chan, 2'd0);
  endtask

  initial begin
    rst_n = 1'b0; trig_req = '0; enable = 4'hF; holdoff = '0; fb = 1'b0; ovf_clr = 1'b0;
    tick(2);
    check_reset_outputs("reset");
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Single request on channel 2: pulse two clocks after the sampling edge.
    trig_req[2] = 1'b1;
    tick(2);
    check("single_early_pulse", pulse, 1'b0);
    tick();
    check("single_pulse", pulse, 1'b1);
    check("single_ack", ack, 4'b0100);
    check("single_chan", chan, 2'd2);
    check("single_count", count, 16'd1);
    tick();
    pulse_fb();
    check("single_busy_after_fb1", busy, 1'b1);
    tick(2);
    pulse_fb();
    check("single_busy_after_fb2", busy, 1'b0);

    // Simultaneous requests from a fresh reset: order 0,1,2,3, no overflow.
    trig_req = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    grants.delete();
    fb_per = 3;
    trig_req = 4'hF;
    tick(60);
    check("simul_n", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) check("simul_order", grants[i], i);
    check("simul_ovf", ovf, 4'h0);

    // Merge/overflow: two ch1 edges while ch0 is being served.
    fb_per = 0; fb = 1'b0;
    trig_req = '0;
    tick();
    grants.delete();
    trig_req[0] = 1'b1;
    tick(4);
    trig_req[1] = 1'b1; tick();
    trig_req[1] = 1'b0; tick();
    trig_req[1] = 1'b1; tick();
    fb_per = 3;
    tick(40);
    check("merge_n", grants.size(), 2);
    if (grants.size() == 2) begin
      check("merge_first", grants[0], 0);
      check("merge_second", grants[1], 1);
    end
    check("merge_ovf", ovf, 4'b0010);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("ovf_cleared", ovf, 4'h0);

    // Holdoff of 5, mid-count holdoff change ignored, request during holdoff.
    fb_per = 0; fb = 1'b0;
    trig_req = '0;
    tick();
    grants.delete();
    holdoff = HW'(5);
    trig_req[2] = 1'b1;
    tick(3);
    pulse_fb();
    tick();
    pulse_fb();
    holdoff = HW'(9);
    trig_req[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("holdoff_busy", busy, 1'b1);
      tick();
    end
    check("holdoff_idle", busy, 1'b0);
    tick();
    check("holdoff_issue_nopulse", pulse, 1'b0);
    tick();
    check("holdoff_req_pulse", pulse, 1'b1);
    check("holdoff_req_ack", ack, 4'b1000);
    holdoff = '0;
    fb_per = 3;
    tick(20);
    check("holdoff_n", grants.size(), 2);

    // Enable masking: ch3 pending, enable dropped before grant.
    fb_per = 0; fb = 1'b0;
    trig_req = '0;
    tick();
    grants.delete();
    trig_req[0] = 1'b1;
    tick(4);
    trig_req[3] = 1'b1;
    tick(2);
    enable[3] = 1'b0;
    tick(2);
    fb_per = 3;
    tick(20);
    enable = 4'hF;
    tick(20);
    check("mask_n", grants.size(), 1);
    if (grants.size() >= 1) check("mask_chan", grants[0], 0);

    // Reset during WAIT_FRAME with a second request pending; held requests give no edge.
    fb_per = 0; fb = 1'b0;
    trig_req = '0;
    tick();
    grants.delete();
    trig_req = 4'b0110;
    tick(3);
    check("midrst_pre_pulse", pulse, 1'b1);
    tick(2);
    check("midrst_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    fb_per = 3;
    tick(30);
    check("midrst_grants", grants.size(), 1);

    // Counter wrap: preload near the top, then two more triggers.
    trig_req = '0;
    tick(2);
    dut.trigger_count_q = 16'hFFFE;
    m_count = 16'hFFFE;
    trig_req = 4'b0011;
    tick(30);
    check("wrap_count", count, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
